instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Fetch/decode/execute controller for the cpu datapath: fetches a 32-bit word from
//  instruction memory, holds it in IReg, issues one execute strobe per instruction,
//  waits for multi-cycle ops (LD/STR), updates PC (sequential or BRA), stops on HLT.
//  Sits between the instruction memory port and cpu; owns PC and the run/halt state.
// PARAMETERS
//  ADDRW   8        PC / instruction address width
//  PSRW    5        width of PSR flags from cpu
//  NOP..CMP 4'h0..4'h9  opcodes: NOP=0 LD=1 STR=2 BRA=3 XOR=4 ADD=5 ROT=6 SHF=7 HLT=8 CMP=9
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      async active-low reset
//  start      in   1      leave IDLE/HALT, begin fetching at PC
//  mem_rdy    in   1      instruction memory ack; mem_rdata valid same cycle
//  mem_rdata  in   32     fetched instruction word
//  PsrIn      in   PSRW   cpu status flags, sampled in EXEC for BRA
//  exe_done   in   1      cpu completed a multi-cycle op (LD/STR)
//  mem_req    out  1      fetch request, held until mem_rdy
//  mem_addr   out  ADDRW  fetch address (= PC)
//  IReg       out  32     current instruction to cpu
//  exe_en     out  1      one-cycle execute strobe to cpu
//  halted     out  1      high in HALT state
//  illegal    out  1      sticky: undefined opcode seen
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, PC=0, IReg=0, mem_req=0, exe_en=0, halted=0, illegal=0.
//  Opcode = IReg[31:28]; BRA cond mask = IReg[27:23] (PSRW bits), target = IReg[ADDRW-1:0].
//  States:
//   IDLE   : outputs quiet; start=1 -> FETCH.
//   FETCH  : mem_req=1, mem_addr=PC; on mem_rdy: IReg<=mem_rdata -> DECODE. No timeout.
//   DECODE : 1 cycle; undefined opcode (>CMP) sets illegal, treated as NOP -> EXEC.
//   EXEC   : exe_en=1 for exactly the first cycle. Then:
//            NOP/XOR/ADD/ROT/SHF/CMP/illegal: PC<=PC+1 -> FETCH (1 cycle).
//            LD/STR: -> WAIT.
//            BRA: if mask==0 or |(mask & PsrIn) then PC<=target else PC<=PC+1; -> FETCH.
//            HLT: PC unchanged -> HALT.
//   WAIT   : exe_en=0; on exe_done: PC<=PC+1 -> FETCH. exe_done in EXEC cycle also
//            accepted (go straight to FETCH).
//   HALT   : halted=1; start=1 -> FETCH at PC+1, halted drops next cycle.
//  Latency: single-cycle op = FETCH(>=1)+DECODE(1)+EXEC(1) = 3 cycles min with mem_rdy=1.
//  PC wraps modulo 2^ADDRW (all-ones +1 -> 0), no flag.
//  start ignored outside IDLE/HALT. exe_done ignored outside EXEC/WAIT.
//  mem_rdy without mem_req ignored. IReg changes only on accepted fetch.
//  rst_n asserted mid-fetch/mid-wait: immediate return to reset values; in-flight
//  instruction discarded; illegal cleared.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: extra input step (1b). After each instruction retires
//   (before next FETCH) FSM enters PAUSE; one-cycle step=1 -> FETCH. start from IDLE
//   goes to PAUSE (not FETCH). HLT still goes to HALT.
//  Not defined: no step port, no PAUSE state; retire -> FETCH directly.
// TESTING
//  1. reset, start, mem words ADD,NOP,HLT, mem_rdy=1 -> exe_en pulses at cycles 3,6,9; halted=1, PC=2.
//  2. LD at PC=0, exe_done 4 cycles after exe_en -> mem_req stays 0 during WAIT; next fetch addr=1.
//  3. BRA mask=5'b00001 target=8'h40, PsrIn=1 -> mem_addr=0x40; PsrIn=0 -> mem_addr=PC+1.
//  4. opcode 4'hF -> illegal=1 sticky, PC advances by 1; stays 1 through later ops until reset.
//  5. PC=8'hFF, NOP -> next mem_addr=8'h00; mem_rdy held low 5 cycles -> mem_req held high 5 cycles.
//  6. rst_n=0 during WAIT -> all outputs reset same cycle; SEQ_SINGLE_STEP_EN: no fetch until step.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute controller in front of the cpu datapath.
// Owns the program counter and the run/halt state. Fetches one 32-bit word per
// instruction, latches it in IReg, pulses exe_en once per instruction, waits on
// exe_done for LD/STR, then advances PC sequentially or to a BRA target. HLT parks
// the FSM in HALT until start.
// Optional build macro: SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state in
// which the FSM waits between instructions (and after start from IDLE).
module instr_sequencer #(
  parameter int ADDRW = 8,
  parameter int PSRW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             mem_rdy,
  input  logic [31:0]      mem_rdata,
  input  logic [PSRW-1:0]  PsrIn,
  input  logic             exe_done,
  output logic             mem_req,
  output logic [ADDRW-1:0] mem_addr,
  output logic [31:0]      IReg,
  output logic             exe_en,
  output logic             halted,
  output logic             illegal
);

  // Opcodes that change control flow; NOP/XOR/ADD/ROT/SHF/CMP (0,4,5,6,7,9) all
  // retire in one EXEC cycle, as does any undefined opcode above CMP.
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_STR = 4'h2;
  localparam logic [3:0] OP_BRA = 4'h3;
  localparam logic [3:0] OP_HLT = 4'h8;
  localparam logic [3:0] OP_CMP = 4'h9;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
`ifdef SEQ_SINGLE_STEP_EN
  localparam logic [2:0] S_PAUSE  = 3'd6;
  // A retiring instruction parks in PAUSE until the next step pulse.
  localparam logic [2:0] S_RETIRE = S_PAUSE;
`else
  localparam logic [2:0] S_RETIRE = S_FETCH;
`endif

  localparam logic [ADDRW-1:0] PC_ONE = {{(ADDRW-1){1'b0}}, 1'b1};

  logic [2:0]       state_reg, state_next;
  logic [ADDRW-1:0] pc_reg, pc_next;
  logic [31:0]      ireg_reg, ireg_next;
  logic             illegal_reg, illegal_next;

  logic [3:0]       opcode;
  logic [PSRW-1:0]  br_mask;
  logic [ADDRW-1:0] br_target;
  logic [ADDRW-1:0] pc_inc;
  logic             br_taken;

  assign opcode    = ireg_reg[31:28];
  assign br_mask   = ireg_reg[27 -: PSRW];
  assign br_target = ireg_reg[ADDRW-1:0];
  // Natural ADDRW-bit wrap: all-ones + 1 -> 0.
  assign pc_inc    = pc_reg + PC_ONE;
  // Empty mask means unconditional; otherwise any selected flag set takes it.
  assign br_taken  = (br_mask == '0) || (|(br_mask & PsrIn));

  // Outputs are pure decodes of the registered state, so an async reset clears
  // them in the same cycle it is asserted.
  assign mem_req  = (state_reg == S_FETCH);
  assign mem_addr = pc_reg;
  assign IReg     = ireg_reg;
  assign exe_en   = (state_reg == S_EXEC);
  assign halted   = (state_reg == S_HALT);
  assign illegal  = illegal_reg;

  // Next-state, PC, instruction-register and illegal-flag logic.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ireg_next    = ireg_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_RETIRE;
      end
      S_FETCH: begin
        // IReg only ever changes on an accepted fetch.
        if (mem_rdy) begin
          ireg_next  = mem_rdata;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode > OP_CMP) illegal_next = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_LD, OP_STR: begin
            // A completion arriving together with the strobe skips WAIT.
            if (exe_done) begin
              pc_next    = pc_inc;
              state_next = S_RETIRE;
            end else begin
              state_next = S_WAIT;
            end
          end
          OP_BRA: begin
            pc_next    = br_taken ? br_target : pc_inc;
            state_next = S_RETIRE;
          end
          OP_HLT: begin
            state_next = S_HALT;
          end
          default: begin
            pc_next    = pc_inc;
            state_next = S_RETIRE;
          end
        endcase
      end
      S_WAIT: begin
        if (exe_done) begin
          pc_next    = pc_inc;
          state_next = S_RETIRE;
        end
      end
      S_HALT: begin
        // Resume past the HLT instruction itself.
        if (start) begin
          pc_next    = pc_inc;
          state_next = S_FETCH;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) state_next = S_FETCH;
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      pc_reg      <= '0;
      ireg_reg    <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ireg_reg    <= ireg_next;
      illegal_reg <= illegal_next;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: reset values, directed timing sequences,
// a table of single-instruction cases and a randomized program run against an
// architectural (instruction-level) reference model.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
`endif
  logic        mem_rdy;
  logic [31:0] mem_rdata;
  logic [4:0]  PsrIn;
  logic        exe_done;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [31:0] IReg;
  logic        exe_en;
  logic        halted;
  logic        illegal;

  logic [31:0] mem [256];
  int checks;
  int failures;

  instr_sequencer #(.ADDRW(8), .PSRW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .PsrIn(PsrIn), .exe_done(exe_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .IReg(IReg), .exe_en(exe_en),
    .halted(halted), .illegal(illegal)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] msk,
                                     input logic [7:0] tgt);
    return {op, msk, 15'h0, tgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; mem_rdy = 1'b0; exe_done = 1'b0; PsrIn = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_mem(input logic [31:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic wait_exe(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (exe_en) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    string      name;
    logic [31:0] instr;
    logic [4:0]  psr;
    logic [7:0]  pc0;
    logic [7:0]  exp_addr;
    logic        exp_ill;
    logic        exp_halt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    bit ok;
    int exe_cyc[$];
    int cnt;
    logic [7:0]  exp_fetch, cur_pc;
    logic [31:0] cur_instr;
    logic [3:0]  op;
    logic [4:0]  msk;
    bit          ill_m, hlt_pending;
    int          retired;

    checks = 0;
    failures = 0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif

    tbl[0]  = '{"add_seq",    mk(4'h5, 5'h00, 8'h00), 5'h00, 8'h10, 8'h11, 1'b0, 1'b0};
    tbl[1]  = '{"nop_wrap",   mk(4'h0, 5'h00, 8'h00), 5'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{"bra_taken",  mk(4'h3, 5'h01, 8'h40), 5'h01, 8'h20, 8'h40, 1'b0, 1'b0};
    tbl[3]  = '{"bra_not",    mk(4'h3, 5'h01, 8'h40), 5'h00, 8'h20, 8'h21, 1'b0, 1'b0};
    tbl[4]  = '{"bra_uncond", mk(4'h3, 5'h00, 8'h77), 5'h00, 8'h30, 8'h77, 1'b0, 1'b0};
    tbl[5]  = '{"bra_multi",  mk(4'h3, 5'h14, 8'h05), 5'h04, 8'h31, 8'h05, 1'b0, 1'b0};
    tbl[6]  = '{"bra_miss",   mk(4'h3, 5'h14, 8'h05), 5'h0B, 8'h31, 8'h32, 1'b0, 1'b0};
    tbl[7]  = '{"ill_f",      mk(4'hF, 5'h00, 8'h00), 5'h00, 8'h40, 8'h41, 1'b1, 1'b0};
    tbl[8]  = '{"ill_a",      mk(4'hA, 5'h00, 8'h00), 5'h00, 8'h41, 8'h42, 1'b1, 1'b0};
    tbl[9]  = '{"cmp_seq",    mk(4'h9, 5'h00, 8'h00), 5'h00, 8'h50, 8'h51, 1'b0, 1'b0};
    tbl[10] = '{"hlt_stay",   mk(4'h8, 5'h00, 8'h00), 5'h00, 8'h60, 8'h60, 1'b0, 1'b1};
    tbl[11] = '{"ld_done",    mk(4'h1, 5'h00, 8'h00), 5'h00, 8'h70, 8'h71, 1'b0, 1'b0};

    // ---- reset values ----
    fill_mem(mk(4'h0, 5'h00, 8'h00));
    rst_n = 1'b0; start = 1'b0; mem_rdy = 1'b0; exe_done = 1'b0; PsrIn = '0;
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ireg", IReg, 0);
    chk("rst_exe_en", exe_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    do_reset();
    tick();
    chk("idle_no_req", mem_req, 0);

    // ---- ADD,NOP,HLT: exe_en at cycles 3,6,9 ----
    fill_mem(mk(4'h0, 5'h00, 8'h00));
    mem[0] = mk(4'h5, 5'h00, 8'h00);
    mem[1] = mk(4'h0, 5'h00, 8'h00);
    mem[2] = mk(4'h8, 5'h00, 8'h00);
    do_reset();
    mem_rdy = 1'b1;
    pulse_start();
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (exe_en) exe_cyc.push_back(cyc);
      tick();
    end
    chk("seq_exe_count", exe_cyc.size(), 3);
    if (exe_cyc.size() == 3) begin
      chk("seq_exe_cyc0", exe_cyc[0], 3);
      chk("seq_exe_cyc1", exe_cyc[1], 6);
      chk("seq_exe_cyc2", exe_cyc[2], 9);
    end
    chk("seq_halted", halted, 1);
    chk("seq_halt_pc", mem_addr, 2);
    pulse_start();
    chk("restart_halted", halted, 0);
    chk("restart_req", mem_req, 1);
    chk("restart_addr", mem_addr, 3);

    // ---- LD with exe_done 4 cycles after exe_en ----
    fill_mem(mk(4'h0, 5'h00, 8'h00));
    mem[0] = mk(4'h1, 5'h00, 8'h00);
    do_reset();
    mem_rdy = 1'b1;
    pulse_start();
    wait_exe(20, ok);
    chk("ld_exe_seen", ok, 1);
    cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) exe_done = 1'b1;
      if (mem_req) cnt++;
    end
    chk("ld_wait_no_req", cnt, 0);
    tick();
    exe_done = 1'b0;
    chk("ld_next_req", mem_req, 1);
    chk("ld_next_addr", mem_addr, 1);

    // ---- table of single-instruction cases ----
    foreach (tbl[k]) begin
      fill_mem(mk(4'h8, 5'h00, 8'h00));
      mem[0] = mk(4'h3, 5'h00, tbl[k].pc0);
      mem[tbl[k].pc0] = tbl[k].instr;
      do_reset();
      PsrIn = tbl[k].psr;
      mem_rdy = 1'b1;
      exe_done = 1'b1;
      pulse_start();
      wait_exe(20, ok);
      tick();
      wait_exe(20, ok);
      chk({tbl[k].name, "_exe"}, ok, 1);
      tick();
      chk({tbl[k].name, "_addr"}, mem_addr, tbl[k].exp_addr);
      chk({tbl[k].name, "_req"}, mem_req, !tbl[k].exp_halt);
      chk({tbl[k].name, "_halt"}, halted, tbl[k].exp_halt);
      chk({tbl[k].name, "_ill"}, illegal, tbl[k].exp_ill);
    end
    exe_done = 1'b0;

    // ---- illegal is sticky through later ops, cleared by reset ----
    fill_mem(mk(4'h0, 5'h00, 8'h00));
    mem[0] = mk(4'hF, 5'h00, 8'h00);
    mem[1] = mk(4'h5, 5'h00, 8'h00);
    mem[2] = mk(4'h1, 5'h00, 8'h00);
    mem[3] = mk(4'h3, 5'h00, 8'h04);
    mem[4] = mk(4'h8, 5'h00, 8'h00);
    do_reset();
    mem_rdy = 1'b1;
    exe_done = 1'b1;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 60 && !halted; i++) begin
      if (exe_en && !illegal) cnt++;
      tick();
    end
    exe_done = 1'b0;
    chk("ill_sticky_gaps", cnt, 0);
    chk("ill_sticky_halt", halted, 1);
    chk("ill_sticky_pc", mem_addr, 4);
    chk("ill_sticky_flag", illegal, 1);
    do_reset();
    chk("ill_cleared", illegal, 0);

    // ---- PC wrap then 5-cycle memory stall ----
    fill_mem(mk(4'h0, 5'h00, 8'h00));
    mem[0] = mk(4'h3, 5'h00, 8'hFF);
    do_reset();
    mem_rdy = 1'b1;
    pulse_start();
    wait_exe(20, ok);
    tick();
    wait_exe(20, ok);
    chk("wrap_exe", ok, 1);
    mem_rdy = 1'b0;
    tick();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req) cnt++;
      tick();
    end
    chk("wrap_addr", mem_addr, 0);
    chk("stall_req_cycles", cnt, 5);
    chk("stall_ireg_hold", IReg, mk(4'h0, 5'h00, 8'h00));
    mem_rdy = 1'b1;
    tick();
    tick();
    chk("stall_ireg_new", IReg, mk(4'h3, 5'h00, 8'hFF));

    // ---- async reset during WAIT ----
    fill_mem(mk(4'h0, 5'h00, 8'h00));
    mem[0] = mk(4'hF, 5'h00, 8'h00);
    mem[1] = mk(4'h2, 5'h00, 8'h00);
    do_reset();
    mem_rdy = 1'b1;
    pulse_start();
    wait_exe(20, ok);
    tick();
    wait_exe(20, ok);
    tick();
    chk("wrst_in_wait", (!mem_req && !exe_en && illegal), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wrst_req", mem_req, 0);
    chk("wrst_addr", mem_addr, 0);
    chk("wrst_ireg", IReg, 0);
    chk("wrst_ill", illegal, 0);
    chk("wrst_exe", exe_en, 0);
    tick();
    rst_n = 1'b1;
    exe_done = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req) cnt++;
      tick();
    end
    exe_done = 1'b0;
    chk("wrst_no_fetch", cnt, 0);

    // ---- randomized program against architectural model ----
    for (int i = 0; i < 256; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h8 && $urandom_range(0, 3) != 0) op = 4'h5;
      msk = ($urandom_range(0, 1) == 0) ? 5'h00 : 5'($urandom);
      mem[i] = mk(op, msk, 8'($urandom));
    end
    do_reset();
    mem_rdy = 1'b1;
    pulse_start();
    exp_fetch = 8'h00;
    cur_pc = 8'h00;
    cur_instr = '0;
    ill_m = 1'b0;
    hlt_pending = 1'b0;
    retired = 0;
    for (int c = 0; c < 20000 && retired < 300; c++) begin
      start    = ($urandom_range(0, 7) == 0);
      mem_rdy  = ($urandom_range(0, 3) != 0);
      exe_done = ($urandom_range(0, 2) == 0);
      PsrIn    = 5'($urandom);
      if (hlt_pending) begin
        chk("rnd_halted", halted, 1);
        hlt_pending = 1'b0;
      end
      if (mem_req && mem_rdy) begin
        chk("rnd_fetch_addr", mem_addr, exp_fetch);
        cur_pc = exp_fetch;
        cur_instr = mem[exp_fetch];
      end
      if (exe_en) begin
        retired++;
        chk("rnd_ireg", IReg, cur_instr);
        op = cur_instr[31:28];
        msk = cur_instr[27:23];
        if (op > 4'h9) ill_m = 1'b1;
        chk("rnd_illegal", illegal, ill_m);
        if (op == 4'h3 && (msk == 0 || (msk & PsrIn) != 0)) exp_fetch = cur_instr[7:0];
        else exp_fetch = cur_pc + 8'd1;
        if (op == 4'h8) hlt_pending = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    chk("rnd_progress", retired, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
